// File: rtl/serial_add_ovf.sv
`default_nettype none
// ============================================================================
//  Module   : serial_add_ovf
//  Purpose  : LSB-first serial adder for two bit streams with per-word
//             framing, completion strobe and unsigned/signed overflow.
//             Optional sticky overflow flag when SERIAL_ADD_STICKY_OVF_EN
//             is defined (adds ovf_clr input and ovf_sticky output).
//  Revision : 1.0  initial release
// ============================================================================
module serial_add_ovf #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic clock,
    input  logic reset,
    input  logic line1,
    input  logic line2,
    input  logic start,
    input  logic mode,
    output logic outp,
    output logic word_done,
    output logic overflw,
    output logic busy
`ifdef SERIAL_ADD_STICKY_OVF_EN
    ,
    input  logic ovf_clr,
    output logic ovf_sticky
`endif
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ADD  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             carry, carry_n;
    logic             mode_q, mode_n;
    logic             outp_n, done_n, ovf_n, busy_n;
    logic             cin, sum_bit, carry_out;

    // Full adder; a start bit always begins a fresh word with carry-in 0
    always_comb begin
        cin       = start ? 1'b0 : carry;
        sum_bit   = line1 ^ line2 ^ cin;
        carry_out = (line1 & line2) | (line1 & cin) | (line2 & cin);
    end

    // Next-state and registered-output logic; start takes priority (abort)
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        carry_n = carry;
        mode_n  = mode_q;
        outp_n  = 1'b0;
        done_n  = 1'b0;
        ovf_n   = 1'b0;
        if (start) begin
            state_n = ADD;
            cnt_n   = CNT_W'(1);
            carry_n = carry_out;
            mode_n  = mode;
            outp_n  = sum_bit;
        end else begin
            case (state)
                IDLE: begin
                    carry_n = 1'b0;
                end
                ADD: begin
                    outp_n = sum_bit;
                    if (cnt == LAST_BIT) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        carry_n = 1'b0;
                        done_n  = 1'b1;
                        // Signed overflow: carry into MSB differs from carry out
                        ovf_n   = mode_q ? (carry ^ carry_out) : carry_out;
                    end else begin
                        cnt_n   = cnt + CNT_W'(1);
                        carry_n = carry_out;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    carry_n = 1'b0;
                end
            endcase
        end
        busy_n = (state_n == ADD);
    end

    // State register and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            carry     <= 1'b0;
            mode_q    <= 1'b0;
            outp      <= 1'b0;
            word_done <= 1'b0;
            overflw   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            carry     <= carry_n;
            mode_q    <= mode_n;
            outp      <= outp_n;
            word_done <= done_n;
            overflw   <= ovf_n;
            busy      <= busy_n;
        end
    end

`ifdef SERIAL_ADD_STICKY_OVF_EN
    // Sticky overflow: a new overflow wins over a simultaneous clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ovf_sticky <= 1'b0;
        end else if (done_n && ovf_n) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ovf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_add_ovf
//  Purpose  : Directed self-checking bench for serial_add_ovf (WIDTH=4).
//             Expected outputs are derived from word-level arithmetic and
//             queued as each bit is driven, then popped one cycle later.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_add_ovf;

    localparam int W = 4;

    typedef struct packed {
        logic outp;
        logic done;
        logic ovf;
        logic busy;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic line1 = 1'b0;
    logic line2 = 1'b0;
    logic start = 1'b0;
    logic mode  = 1'b0;
    logic ovf_clr = 1'b0;
    logic outp, word_done, overflw, busy;
`ifdef SERIAL_ADD_STICKY_OVF_EN
    logic ovf_sticky;
`endif

    int   checks   = 0;
    int   failures = 0;
    logic exp_sticky = 1'b0;
    exp_t sb[$];

    always #5 clock = ~clock;

    serial_add_ovf #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .line1     (line1),
        .line2     (line2),
        .start     (start),
        .mode      (mode),
        .outp      (outp),
        .word_done (word_done),
        .overflw   (overflw),
        .busy      (busy)
`ifdef SERIAL_ADD_STICKY_OVF_EN
        ,
        .ovf_clr   (ovf_clr),
        .ovf_sticky(ovf_sticky)
`endif
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_sticky(input string tag);
`ifdef SERIAL_ADD_STICKY_OVF_EN
        check(tag, ovf_sticky, exp_sticky);
`endif
    endtask

    // Drive one input cycle, queue its expected output, compare after the edge
    task automatic drive_bit(input logic l1, input logic l2, input logic st,
                             input logic md, input logic clr, input exp_t e,
                             input string tag);
        exp_t got;
        logic sticky_next;
        @(negedge clock);
        line1   = l1;
        line2   = l2;
        start   = st;
        mode    = md;
        ovf_clr = clr;
        sb.push_back(e);
        sticky_next = (e.done && e.ovf) || (exp_sticky && !clr);
        @(posedge clock);
        #1;
        exp_sticky = sticky_next;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            got = sb.pop_front();
            check({tag, ".outp"}, outp, got.outp);
            check({tag, ".done"}, word_done, got.done);
            check({tag, ".ovf"},  overflw, got.ovf);
            check({tag, ".busy"}, busy, got.busy);
            check_sticky({tag, ".sticky"});
        end
    endtask

    task automatic idle(input logic l1, input logic l2, input logic clr, input string tag);
        drive_bit(l1, l2, 1'b0, 1'b0, clr, exp_t'(4'b0000), tag);
    endtask

    // Send the first nbits of a word; expectations from integer arithmetic
    task automatic send_word(input logic [3:0] a, input logic [3:0] b,
                             input logic md, input int nbits,
                             input logic clr_msb, input string tag);
        logic [4:0] sum;
        int   sa, sb_i, ss;
        logic ovf;
        exp_t e;
        sum  = {1'b0, a} + {1'b0, b};
        sa   = a[3] ? int'(a) - 16 : int'(a);
        sb_i = b[3] ? int'(b) - 16 : int'(b);
        ss   = sa + sb_i;
        ovf  = md ? ((ss > 7) || (ss < -8)) : sum[4];
        for (int i = 0; i < nbits; i++) begin
            e.outp = sum[i];
            e.done = (i == W - 1);
            e.ovf  = (i == W - 1) ? ovf : 1'b0;
            e.busy = (i != W - 1);
            drive_bit(a[i], b[i], (i == 0), md, (i == W - 1) ? clr_msb : 1'b0,
                      e, $sformatf("%s.b%0d", tag, i));
        end
    endtask

    initial begin
        // Reset state while reset is held low
        #12;
        check("rst.outp", outp, 1'b0);
        check("rst.done", word_done, 1'b0);
        check("rst.ovf",  overflw, 1'b0);
        check("rst.busy", busy, 1'b0);
        check_sticky("rst.sticky");
        @(negedge clock);
        reset = 1'b1;

        // Idle with active data but no start: nothing happens
        idle(1'b1, 1'b1, 1'b0, "idle0");
        idle(1'b1, 1'b0, 1'b0, "idle1");

        // Main arithmetic cases
        send_word(4'h3, 4'h5, 1'b0, 4, 1'b0, "u3p5");
        send_word(4'h3, 4'h5, 1'b1, 4, 1'b0, "s3p5");
        idle(1'b0, 1'b0, 1'b0, "idle2");
        send_word(4'hF, 4'h1, 1'b0, 4, 1'b0, "uFp1");
        send_word(4'hF, 4'h1, 1'b1, 4, 1'b0, "sFp1");
        idle(1'b1, 1'b1, 1'b0, "idle3");

        // Back-to-back words; second must not inherit carry
        send_word(4'hF, 4'h1, 1'b0, 4, 1'b0, "b2b0");
        send_word(4'h2, 4'h2, 1'b0, 4, 1'b0, "b2b1");

        // Clear pulse drops the sticky flag
        idle(1'b0, 1'b0, 1'b1, "clr");
        idle(1'b0, 1'b0, 1'b0, "postclr");

        // Clear coincident with an overflow completion: set wins
        send_word(4'h8, 4'h8, 1'b0, 4, 1'b1, "setwin");
        idle(1'b0, 1'b0, 1'b0, "idle4");

        // Abort by start on bit 2, then a full signed-overflow word
        send_word(4'h6, 4'h7, 1'b0, 2, 1'b0, "abort");
        send_word(4'h5, 4'h6, 1'b1, 4, 1'b0, "s5p6");

        // Start coincident with the MSB input aborts that word
        send_word(4'h1, 4'h2, 1'b0, 3, 1'b0, "abmsb");
        send_word(4'h4, 4'h4, 1'b1, 4, 1'b0, "s4p4");
        send_word(4'h7, 4'hA, 1'b1, 4, 1'b0, "s7pA");

        // Reset during bit 1 of a word: outputs drop immediately
        send_word(4'h9, 4'h9, 1'b0, 1, 1'b0, "rstw");
        @(negedge clock);
        line1 = 1'b1;
        line2 = 1'b1;
        start = 1'b0;
        reset = 1'b0;
        #1;
        exp_sticky = 1'b0;
        sb.delete();
        check("midrst.outp", outp, 1'b0);
        check("midrst.done", word_done, 1'b0);
        check("midrst.ovf",  overflw, 1'b0);
        check("midrst.busy", busy, 1'b0);
        check_sticky("midrst.sticky");
        @(negedge clock);
        reset = 1'b1;
        idle(1'b1, 1'b1, 1'b0, "postrst0");
        idle(1'b1, 1'b0, 1'b0, "postrst1");
        send_word(4'hA, 4'h3, 1'b0, 4, 1'b0, "uAp3");
        send_word(4'hC, 4'h6, 1'b0, 4, 1'b0, "uCp6");
        idle(1'b0, 1'b0, 1'b0, "tail");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
